// File: rtl/seq_mag_cmp_pkg.sv
// Shared types and constants for the sequential multi-nibble magnitude comparator.
package seq_mag_cmp_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // One-hot compare verdict.
  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } res_t;

  localparam res_t RES_EQ = '{eq: 1'b1, gt: 1'b0, lt: 1'b0};
  localparam res_t RES_GT = '{eq: 1'b0, gt: 1'b1, lt: 1'b0};
  localparam res_t RES_LT = '{eq: 1'b0, gt: 1'b0, lt: 1'b1};

endpackage

// File: rtl/seq_mag_cmp_comp_nibble.sv
// Combinational 4-bit unsigned compare slice producing a one-hot eq/gt/lt verdict.
module comp_nibble
  import seq_mag_cmp_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  output res_t             res_o
);

  // Unsigned magnitude compare of one nibble pair.
  always_comb begin
    res_o = RES_EQ;
    if (a_i > b_i) begin
      res_o = RES_GT;
    end else if (a_i < b_i) begin
      res_o = RES_LT;
    end
  end

endmodule

// File: rtl/seq_mag_cmp.sv
// Sequential multi-nibble magnitude comparator: walks the operands MSB nibble first
// through a single compare slice and reports a one-hot eq/gt/lt result with a done pulse.
// Optional macro SEQ_MAG_CMP_EARLY_EXIT_EN: finish as soon as the first unequal nibble is seen.
module seq_mag_cmp
  import seq_mag_cmp_pkg::*;
#(
  parameter int unsigned NIBBLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NIB_W*NIBBLES-1:0] a,
  input  logic [NIB_W*NIBBLES-1:0] b,
  output logic                     ready,
  output logic                     done,
  output logic                     aeb,
  output logic                     agb,
  output logic                     alb
);

  localparam int unsigned W        = NIB_W * NIBBLES;
  localparam int unsigned IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             decided_q, decided_d;
  res_t             verdict_q, verdict_d;
  res_t             res_q, res_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic [NIB_W-1:0] nib_a_c, nib_b_c;
  res_t             slice_c;
  res_t             final_c;
  logic             accept_c, last_c, finish_c;

  // Index mux selecting the current nibble pair from the captured operands.
  assign nib_a_c = NIB_W'(a_q >> (NIB_W * idx_q));
  assign nib_b_c = NIB_W'(b_q >> (NIB_W * idx_q));

  comp_nibble u_slice (
    .a_i  (nib_a_c),
    .b_i  (nib_b_c),
    .res_o(slice_c)
  );

  assign accept_c = start && (state_q == ST_IDLE);
  assign last_c   = (idx_q == '0);
  // A recorded decision from a higher nibble always dominates the current slice.
  assign final_c  = decided_q ? verdict_q : slice_c;

`ifdef SEQ_MAG_CMP_EARLY_EXIT_EN
  assign finish_c = (state_q == ST_RUN) && (last_c || (!decided_q && !slice_c.eq));
`else
  assign finish_c = (state_q == ST_RUN) && last_c;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_c) state_d = ST_RUN;
      ST_RUN:  if (finish_c) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    decided_d = decided_q;
    verdict_d = verdict_q;
    res_d     = res_q;
    done_d    = 1'b0;
    ready_d   = (state_d == ST_IDLE);
    if (accept_c) begin
      a_d       = a;
      b_d       = b;
      idx_d     = IDX_LAST;
      decided_d = 1'b0;
      verdict_d = '0;
    end else if (state_q == ST_RUN) begin
      if (!last_c) begin
        idx_d = idx_q - IDX_W'(1);
      end
      if (!decided_q && !slice_c.eq) begin
        decided_d = 1'b1;
        verdict_d = slice_c;
      end
      if (finish_c) begin
        res_d  = final_c;
        done_d = 1'b1;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      verdict_q <= '0;
      res_q     <= '0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      verdict_q <= verdict_d;
      res_q     <= res_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign aeb   = res_q.eq;
  assign agb   = res_q.gt;
  assign alb   = res_q.lt;

endmodule

// File: tb/tb_seq_mag_cmp.sv
// Directed bench for seq_mag_cmp with a 2-nibble and a 4-nibble instance.
module tb_seq_mag_cmp;

`ifdef SEQ_MAG_CMP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  localparam logic [2:0] R_EQ = 3'b100;
  localparam logic [2:0] R_GT = 3'b010;
  localparam logic [2:0] R_LT = 3'b001;

  logic clk = 1'b0;
  logic rst_n;

  logic        start2, ready2, done2, aeb2, agb2, alb2;
  logic [7:0]  a2, b2;
  logic        start4, ready4, done4, aeb4, agb4, alb4;
  logic [15:0] a4, b4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_mag_cmp #(.NIBBLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .ready(ready2), .done(done2), .aeb(aeb2), .agb(agb2), .alb(alb2)
  );

  seq_mag_cmp #(.NIBBLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .ready(ready4), .done(done4), .aeb(aeb4), .agb(agb4), .alb(alb4)
  );

  typedef struct {
    bit          n4;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  res;
    int          lat;
    int          lat_ee;
    string       nm;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Issue one compare on the selected instance and check latency, result and pulse width.
  task automatic do_cmp(input bit n4, input logic [15:0] av, input logic [15:0] bv,
                        input logic [2:0] er, input int el, input string nm);
    int cyc;
    bit seen;
    logic [2:0] r;
    @(negedge clk);
    if (n4) begin
      chk({nm, "_ready_idle"}, 32'(ready4), 32'd1);
      start4 = 1'b1; a4 = av; b4 = bv;
    end else begin
      chk({nm, "_ready_idle"}, 32'(ready2), 32'd1);
      start2 = 1'b1; a2 = av[7:0]; b2 = bv[7:0];
    end
    @(posedge clk);
    #1 start2 = 1'b0; start4 = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      seen = n4 ? done4 : done2;
    end
    chk({nm, "_latency"}, 32'(cyc), 32'(el));
    r = n4 ? {aeb4, agb4, alb4} : {aeb2, agb2, alb2};
    chk({nm, "_result"}, 32'(r), 32'(er));
    chk({nm, "_ready_done"}, 32'(n4 ? ready4 : ready2), 32'd1);
    @(negedge clk);
    chk({nm, "_done_pulse"}, 32'(n4 ? done4 : done2), 32'd0);
    r = n4 ? {aeb4, agb4, alb4} : {aeb2, agb2, alb2};
    chk({nm, "_hold"}, 32'(r), 32'(er));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit seen;

    // 4-nibble instance uses 16-bit operands; values are the low halves of the 32-bit examples.
    vecs[0]  = '{1'b0, 16'h00A5, 16'h00A5, R_EQ, 2, 2, "a5_a5"};
    vecs[1]  = '{1'b0, 16'h003F, 16'h0040, R_LT, 2, 1, "3f_40"};
    vecs[2]  = '{1'b0, 16'h0057, 16'h0052, R_GT, 2, 2, "57_52"};
    vecs[3]  = '{1'b0, 16'h0000, 16'h0000, R_EQ, 2, 2, "00_00"};
    vecs[4]  = '{1'b0, 16'h00FF, 16'h0000, R_GT, 2, 1, "ff_00"};
    vecs[5]  = '{1'b0, 16'h000E, 16'h000F, R_LT, 2, 2, "0e_0f"};
    vecs[6]  = '{1'b1, 16'h5679, 16'h5678, R_GT, 4, 4, "5679_5678"};
    vecs[7]  = '{1'b1, 16'h5678, 16'h5679, R_LT, 4, 4, "5678_5679"};
    vecs[8]  = '{1'b1, 16'h8000, 16'h7FFF, R_GT, 4, 1, "8000_7fff"};
    vecs[9]  = '{1'b1, 16'hFFFF, 16'hFFFF, R_EQ, 4, 4, "ffff_ffff"};
    vecs[10] = '{1'b1, 16'h1234, 16'h1243, R_LT, 4, 3, "1234_1243"};
    vecs[11] = '{1'b1, 16'h0000, 16'h0001, R_LT, 4, 4, "0000_0001"};

    rst_n = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready2", 32'(ready2), 32'd1);
    chk("rst_done2", 32'(done2), 32'd0);
    chk("rst_res2", 32'({aeb2, agb2, alb2}), 32'd0);
    chk("rst_ready4", 32'(ready4), 32'd1);
    chk("rst_res4", 32'({aeb4, agb4, alb4}), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      do_cmp(vecs[i].n4, vecs[i].a, vecs[i].b, vecs[i].res,
             EE ? vecs[i].lat_ee : vecs[i].lat, vecs[i].nm);
    end

    // Back-to-back with a busy-time start carrying different operands.
    @(negedge clk);
    start2 = 1'b1; a2 = 8'h10; b2 = 8'h01;
    @(posedge clk);
    @(negedge clk);
    a2 = 8'hFF; b2 = 8'h00;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      seen = done2;
      if (!seen) chk("b2b_busy_ready", 32'(ready2), 32'd0);
    end
    chk("b2b_first_latency", 32'(cyc), EE ? 32'd1 : 32'd2);
    chk("b2b_first_result", 32'({aeb2, agb2, alb2}), 32'(R_GT));
    chk("b2b_done_ready", 32'(ready2), 32'd1);
    a2 = 8'h01; b2 = 8'h10;
    @(posedge clk);
    #1 start2 = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      seen = done2;
      if (!seen) chk("b2b_hold_gt", 32'({aeb2, agb2, alb2}), 32'(R_GT));
    end
    chk("b2b_second_latency", 32'(cyc), EE ? 32'd1 : 32'd2);
    chk("b2b_second_result", 32'({aeb2, agb2, alb2}), 32'(R_LT));
    @(negedge clk);
    chk("b2b_done_pulse", 32'(done2), 32'd0);

    // Reset mid-operation aborts with no done pulse.
    @(negedge clk);
    start2 = 1'b1; a2 = 8'h80; b2 = 8'h7F;
    @(posedge clk);
    #1 start2 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_res2", 32'({aeb2, agb2, alb2}), 32'd0);
    chk("abort_ready2", 32'(ready2), 32'd1);
    chk("abort_done2", 32'(done2), 32'd0);
    chk("abort_res4", 32'({aeb4, agb4, alb4}), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_done_in_rst", 32'(done2), 32'd0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done2), 32'd0);
      chk("abort_ready_after", 32'(ready2), 32'd1);
    end
    do_cmp(1'b0, 16'h0080, 16'h007F, R_GT, EE ? 1 : 2, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
